// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/issue controller: FSM state
// encodings, forwarding select encodings and the scoreboard entry layout.
// Optional feature macro: PIPE_HAZARD_FWD_EN (operand forwarding).
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    // Forwarding source for an EX operand
    localparam logic [1:0] FWD_RF    = 2'd0;  // register file
    localparam logic [1:0] FWD_EXMEM = 2'd1;  // EX/MEM result
    localparam logic [1:0] FWD_MEMWB = 2'd2;  // MEM/WB result
    localparam logic [1:0] FWD_WB    = 2'd3;  // WB write data

    localparam int SB_DEPTH   = 3;   // EX, MEM, WB
    localparam int SB_ENTRY_W = 5;   // {v, rg[2:0], ld}

    // Drain length after a halt issues (instructions ahead of it)
    localparam logic [1:0] DRAIN_LOAD = 2'd3;

    typedef struct packed {
        logic       v;
        logic [2:0] rg;
        logic       ld;
    } sb_entry_t;

    // Youngest producer wins: EX entry beats MEM, MEM beats WB.
    function automatic logic [1:0] fwd_select(input logic [SB_DEPTH-1:0] match);
        logic [1:0] sel;
        if (match[0]) begin
            sel = FWD_EXMEM;
        end else if (match[1]) begin
            sel = FWD_MEMWB;
        end else if (match[2]) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-stage hazard control bundle: ID-stage instruction info and the
// redirect from EX in, pipeline control out.
// Optional feature macro: PIPE_HAZARD_FWD_EN adds fwd_a_sel / fwd_b_sel.
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 16);
    logic             id_valid;
    logic             id_rs_used;
    logic             id_rt_used;
    logic [2:0]       id_rs;
    logic [2:0]       id_rt;
    logic             id_wr_en;
    logic [2:0]       id_wr_reg;
    logic             id_mem_rd;
    logic             id_halt;
    logic             ex_redirect;
    logic             pc_write_en;
    logic             ifid_write_en;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
`ifdef PIPE_HAZARD_FWD_EN
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;

    modport master (
        output id_valid, id_rs_used, id_rt_used, id_rs, id_rt, id_wr_en,
               id_wr_reg, id_mem_rd, id_halt, ex_redirect,
        input  pc_write_en, ifid_write_en, ifid_flush, idex_bubble, halted,
               stall_cnt, fwd_a_sel, fwd_b_sel
    );
    modport slave (
        input  id_valid, id_rs_used, id_rt_used, id_rs, id_rt, id_wr_en,
               id_wr_reg, id_mem_rd, id_halt, ex_redirect,
        output pc_write_en, ifid_write_en, ifid_flush, idex_bubble, halted,
               stall_cnt, fwd_a_sel, fwd_b_sel
    );
`else
    modport master (
        output id_valid, id_rs_used, id_rt_used, id_rs, id_rt, id_wr_en,
               id_wr_reg, id_mem_rd, id_halt, ex_redirect,
        input  pc_write_en, ifid_write_en, ifid_flush, idex_bubble, halted,
               stall_cnt
    );
    modport slave (
        input  id_valid, id_rs_used, id_rt_used, id_rs, id_rt, id_wr_en,
               id_wr_reg, id_mem_rd, id_halt, ex_redirect,
        output pc_write_en, ifid_write_en, ifid_flush, idex_bubble, halted,
               stall_cnt
    );
`endif
endinterface

// File: rtl/pipe_hazard_ctrl_sb_src_match.sv
// Compares one source register of the decoding instruction against every
// in-flight scoreboard entry. Returns a per-entry match vector and the same
// vector qualified by the entry's load flag.
module sb_src_match
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic                       i_used,
    input  logic [2:0]                 i_src,
    input  sb_entry_t [SB_DEPTH-1:0]   i_sb,
    output logic [SB_DEPTH-1:0]        o_match,
    output logic [SB_DEPTH-1:0]        o_ld
);

    // Per-entry source/destination compare; unused source fields never match
    always_comb begin
        o_match = {SB_DEPTH{1'b0}};
        o_ld    = {SB_DEPTH{1'b0}};
        for (int k = 0; k < SB_DEPTH; k++) begin
            o_match[k] = i_used & i_sb[k].v & (i_sb[k].rg == i_src);
            o_ld[k]    = o_match[k] & i_sb[k].ld;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Decode-stage hazard and issue controller for the 5-stage 16-bit core.
// Tracks in-flight register writes in a 3-entry scoreboard (EX, MEM, WB),
// stalls IF/ID and PC on RAW hazards, squashes on EX redirects and drains
// the pipe after a halt. Optional feature macro: PIPE_HAZARD_FWD_EN
// (operand forwarding selects; stalls reduce to load-use only).
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
)
(
    input  logic                 clk,
    input  logic                 rst,     // asynchronous, active low
    pipe_hazard_ctrl_if.slave    bus
);

    state_e                    r_state;
    state_e                    w_state_nxt;
    logic [1:0]                r_drain_cnt;
    logic [1:0]                w_drain_nxt;
    sb_entry_t [SB_DEPTH-1:0]  r_sb;
    sb_entry_t                 w_sb_new;
    logic [CNT_W-1:0]          r_stall_cnt;

    logic [SB_DEPTH-1:0]       w_match_rs;
    logic [SB_DEPTH-1:0]       w_match_rt;
    logic [SB_DEPTH-1:0]       w_ld_rs;
    logic [SB_DEPTH-1:0]       w_ld_rt;
    logic                      w_hazard;
    logic                      w_run;
    logic                      w_stall;
    logic                      w_issue;
    logic                      w_pc_we;
    logic                      w_bubble;
    logic                      w_flush;

    sb_src_match u_match_rs (
        .i_used  (bus.id_rs_used),
        .i_src   (bus.id_rs),
        .i_sb    (r_sb),
        .o_match (w_match_rs),
        .o_ld    (w_ld_rs)
    );

    sb_src_match u_match_rt (
        .i_used  (bus.id_rt_used),
        .i_src   (bus.id_rt),
        .i_sb    (r_sb),
        .o_match (w_match_rt),
        .o_ld    (w_ld_rt)
    );

`ifdef PIPE_HAZARD_FWD_EN
    // With forwarding only a load still in EX cannot supply its data in time
    assign w_hazard = w_ld_rs[0] | w_ld_rt[0];
`else
    // No bypass anywhere (not even in the register file): any in-flight
    // producer stalls. Load matches are a subset of the plain matches.
    assign w_hazard = (|w_match_rs) | (|w_match_rt) | (|w_ld_rs) | (|w_ld_rt);
`endif

    assign w_run   = (r_state == ST_RUN);
    // A redirect kills the ID instruction, so it can neither stall nor issue
    assign w_stall = bus.id_valid & w_hazard & w_run & ~bus.ex_redirect;
    assign w_issue = bus.id_valid & ~w_hazard & w_run & ~bus.ex_redirect;

    // Next-state logic and pipeline control outputs
    always_comb begin
        w_state_nxt = r_state;
        w_drain_nxt = r_drain_cnt;
        w_pc_we     = 1'b0;
        w_bubble    = 1'b1;
        w_flush     = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_pc_we  = ~w_stall;
                w_bubble = ~w_issue;
                w_flush  = bus.ex_redirect;
                if (w_issue && bus.id_halt) begin
                    w_state_nxt = ST_DRAIN;
                    w_drain_nxt = DRAIN_LOAD;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // Counter reaches zero on the same edge that enters HALTED,
                // i.e. the 4th edge after the halt issued
                if (r_drain_cnt <= 2'd1) begin
                    w_state_nxt = ST_HALTED;
                    w_drain_nxt = 2'd0;
                end else begin
                    w_drain_nxt = r_drain_cnt - 2'd1;
                end
            end
            ST_HALTED: begin
                w_state_nxt = ST_HALTED;
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_drain_nxt = 2'd0;
            end
        endcase
    end

    // New EX scoreboard entry: the issuing instruction, or an empty slot
    always_comb begin
        w_sb_new = {SB_ENTRY_W{1'b0}};
        if (w_issue) begin
            w_sb_new.v  = bus.id_wr_en;
            w_sb_new.rg = bus.id_wr_reg;
            w_sb_new.ld = bus.id_mem_rd;
        end else begin
            w_sb_new.v  = 1'b0;
        end
    end

    // FSM state and drain counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_RUN;
            r_drain_cnt <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
        end
    end

    // Scoreboard advances one stage every cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sb <= {(SB_DEPTH*SB_ENTRY_W){1'b0}};
        end else begin
            r_sb <= {r_sb[1], r_sb[0], w_sb_new};
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= {CNT_W{1'b0}};
        end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

`ifdef PIPE_HAZARD_FWD_EN
    logic [1:0] r_fwd_a;
    logic [1:0] r_fwd_b;

    // Forwarding selects travel with the instruction into EX; bubbles read RF
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fwd_a <= FWD_RF;
            r_fwd_b <= FWD_RF;
        end else if (w_issue) begin
            r_fwd_a <= fwd_select(w_match_rs);
            r_fwd_b <= fwd_select(w_match_rt);
        end else begin
            r_fwd_a <= FWD_RF;
            r_fwd_b <= FWD_RF;
        end
    end

    assign bus.fwd_a_sel = r_fwd_a;
    assign bus.fwd_b_sel = r_fwd_b;
`endif

    // While reset is held the front end is frozen and ID/EX gets bubbles
    assign bus.pc_write_en   = rst & w_pc_we;
    assign bus.ifid_write_en = rst & w_pc_we;
    assign bus.idex_bubble   = ~rst | w_bubble;
    assign bus.ifid_flush    = rst & w_flush;
    assign bus.halted        = (r_state == ST_HALTED);
    assign bus.stall_cnt     = r_stall_cnt;

endmodule
